ah_pl2ddr_burst_planner: RTL
============================

# ah_pl2ddr_burst_planner

Sequential, parametrised burst planner for the PL-to-DDR write path. It sits between the stream FIFO and the AXI write master. It turns a FIFO fill level and a DDR target window into a sequence of power-of-two write bursts, handed over on a valid/ready plan interface. Unlike the previous combinational calculator, it supports:
- configurable beat width and maximum burst length;
- trimming of bursts so none crosses a 4 KB AXI boundary or the window end;
- waiting for write completion before planning the next burst;
- optional ring-buffer wrap.

## Interface
- ADDR_W, 32, DDR byte-address width.
- AVAIL_W, 10, width of the FIFO fill level in beats.
- DATA_BYTES, 4, bytes per beat; power of two, 1..128.
- MAX_BURST, 256, maximum beats per burst; power of two, 1..256.
- LEN_W, $clog2(MAX_BURST)+1, width of plan_beats.
- clk  in  1  single clock for all logic.
- rst_n  in  1  reset, asynchronous, active-low.
- arm  in  1  pulse; latches addr_low/addr_high, clears offset and wrap_cnt, starts planning.
- addr_low  in  ADDR_W  window start, DATA_BYTES-aligned.
- addr_high  in  ADDR_W  window end (exclusive), DATA_BYTES-aligned, greater than addr_low.
- data_available  in  AVAIL_W  FIFO fill level in beats.
- plan_valid  out  1  plan fields are valid.
- plan_ready  in  1  write master accepts the plan.
- plan_addr  out  ADDR_W  equals window_low + offset.
- plan_beats  out  LEN_W  burst length in beats.
- plan_awlen  out  8  equals plan_beats-1.
- burst_done  in  1  pulse; the accepted burst has been written and data_available has been updated.
- offset  out  ADDR_W  current byte offset into the window.
- full  out  1  window exhausted (sticky, no-wrap build only).
- wrap_cnt  out  16  number of window wraps.
- busy  out  1  state is neither IDLE nor FULL.

## Operation
- States and transitions:
  - IDLE: arm goes to SCAN.
  - SCAN:
    - if remaining < DATA_BYTES, go to FULL (or take the wrap path);
    - else if data_available ≥ 1, go to TRIM and load cand = the largest power of two ≤ min(data_available, MAX_BURST).
  - TRIM: if cand*DATA_BYTES ≤ min(remaining, to_4k), go to OFFER; else halve cand and stay in TRIM.
  - OFFER: plan_valid=1; on plan_ready, offset += plan_beats*DATA_BYTES, then go to BUSY.
  - BUSY: burst_done goes to SCAN.
  - FULL: stays in FULL until arm.
- Arithmetic:
  - remaining = (high − low) − offset;
  - to_4k = 4096 − (plan_addr[11:0]);
  - both are computed at ADDR_W+1 bits with no truncation.
- TRIM always terminates at cand ≥ 1, because remaining ≥ DATA_BYTES and alignment guarantee to_4k ≥ DATA_BYTES.
- data_available is sampled only in SCAN; its later changes do not alter a plan in progress.
- Plan fields are registered and held stable while plan_valid=1.
- arm in any state:
  - aborts the current operation and drops plan_valid the next cycle;
  - reloads the window, sets offset=0, and enters SCAN.
- arm wins over simultaneous plan_ready or burst_done.
- burst_done outside BUSY is ignored.
- plan_ready outside OFFER is ignored.

## Timing
- Reset (asynchronous, rst_n low): state=IDLE, plan_valid=0, plan_addr=0, plan_beats=0, plan_awlen=0, offset=0, full=0, wrap_cnt=0, busy=0.
- arm at cycle n puts the block in SCAN at n+1.
- SCAN with data present at cycle c puts the block in TRIM at c+1.
- plan_valid rises at c+2+k, where k is the number of halvings (max log2(MAX_BURST)).
- Handshake: transfer happens on the rising edge with plan_valid=plan_ready=1. plan_valid falls the next cycle, and offset updates on that same edge.
- burst_done at cycle d puts the block in SCAN at d+1.
- full asserts one cycle after SCAN detects exhaustion.

## Configuration
- Macro: AH_PL2DDR_PLAN_WRAP_EN.
- Defined: on exhaustion, SCAN sets offset=0, increments wrap_cnt (saturating at 0xFFFF) and stays in SCAN; full stays 0.
- Undefined: exhaustion enters FULL with full=1; wrap_cnt is tied to 0.

## Test plan
All scenarios use DATA_BYTES=4 and MAX_BURST=256.
- Full-size burst: arm with low=0x10000000, high=0x10001000, avail=300 → plan_addr=0x10000000, beats=256, awlen=255, valid 2 cycles after SCAN. Accept, then burst_done → offset=0x400, next plan at 0x10000400.
- Non-power-of-two fill: avail=37 → beats=32, awlen=31, no halving.
- 4 KB trim: low=0x10000F00, high=0x10002000, avail=256 → beats=64 (to_4k=0x100), plan_valid at SCAN+4.
- Window end:
  - low=0, high=0x40, avail=100 → beats=16;
  - after burst_done, full=1, busy=0 (macro undefined);
  - macro defined: offset=0, wrap_cnt=1, new plan at 0.
- Abort: arm during OFFER with plan_ready=0 → plan_valid=0 next cycle, offset=0, new plan from the new window.
- Reset mid-operation: rst_n low during TRIM → all outputs at their reset values immediately, without waiting for a clock edge. No plan after release until arm.

Source files
------------

// File: rtl/ah_pl2ddr_burst_planner_if.sv
// Plan handshake between the burst planner (master) and the AXI write master
// (slave). The planner offers one burst at a time on a valid/ready pair.
interface ah_pl2ddr_burst_planner_if #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 9
);
  logic              plan_valid;
  logic              plan_ready;
  logic [ADDR_W-1:0] plan_addr;
  logic [LEN_W-1:0]  plan_beats;
  logic [7:0]        plan_awlen;

  modport master (
    output plan_valid,
    output plan_addr,
    output plan_beats,
    output plan_awlen,
    input  plan_ready
  );

  modport slave (
    input  plan_valid,
    input  plan_addr,
    input  plan_beats,
    input  plan_awlen,
    output plan_ready
  );
endinterface

// File: rtl/ah_pl2ddr_burst_planner.sv
// PL-to-DDR burst planner. Converts a FIFO fill level and a DDR window into a
// sequence of power-of-two write bursts that never cross a 4 KB boundary or
// the window end, waiting for each burst to complete before planning the next.
// Optional ring-buffer wrap on window exhaustion: AH_PL2DDR_PLAN_WRAP_EN.
module ah_pl2ddr_burst_planner #(
  parameter int ADDR_W     = 32,
  parameter int AVAIL_W    = 10,
  parameter int DATA_BYTES = 4,
  parameter int MAX_BURST  = 256,
  parameter int LEN_W      = $clog2(MAX_BURST) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_arm,
  input  logic [ADDR_W-1:0]    i_addr_low,
  input  logic [ADDR_W-1:0]    i_addr_high,
  input  logic [AVAIL_W-1:0]   i_data_available,
  input  logic                 i_burst_done,
  ah_pl2ddr_burst_planner_if.master plan_if,
  output logic [ADDR_W-1:0]    o_offset,
  output logic                 o_full,
  output logic [15:0]          o_wrap_cnt,
  output logic                 o_busy
);

  localparam int DB_SH = $clog2(DATA_BYTES);
  localparam int XW    = ADDR_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_TRIM  = 3'd2,
    ST_OFFER = 3'd3,
    ST_BUSY  = 3'd4,
    ST_FULL  = 3'd5
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_low;
  logic [ADDR_W-1:0] r_high;
  logic [ADDR_W-1:0] r_offset;
  logic [LEN_W-1:0]  r_cand;
  logic              r_plan_valid;
  logic [ADDR_W-1:0] r_plan_addr;
  logic [LEN_W-1:0]  r_plan_beats;
  logic [7:0]        r_plan_awlen;
  logic              r_full;
  logic [15:0]       r_wrap_cnt;
  logic              r_busy;

  logic [XW-1:0]     w_span;
  logic [XW-1:0]     w_remaining;
  logic [XW-1:0]     w_to_4k;
  logic [XW-1:0]     w_limit;
  logic [XW-1:0]     w_cand_bytes;
  logic              w_exhausted;
  logic [LEN_W-1:0]  w_avail_cap;
  logic [ADDR_W-1:0] w_beat_bytes;
  logic [ADDR_W-1:0] w_scan_addr;

  // Largest power of two not exceeding v (v is non-zero when used).
  function automatic logic [LEN_W-1:0] pow2_floor(input logic [LEN_W-1:0] v);
    logic [LEN_W-1:0] r;
    r = '0;
    for (int i = 0; i < LEN_W; i++) begin
      if (v[i]) begin
        r = LEN_W'(1) << i;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Window arithmetic is done one bit wider than the address so nothing wraps.
  always_comb begin
    w_span       = XW'(r_high) - XW'(r_low);
    w_remaining  = w_span - XW'(r_offset);
    w_to_4k      = XW'(13'h1000) - XW'(r_plan_addr[11:0]);
    w_cand_bytes = XW'(r_cand) << DB_SH;
    w_beat_bytes = ADDR_W'(r_plan_beats) << DB_SH;
    w_scan_addr  = r_low + r_offset;
    w_exhausted  = (w_remaining < XW'(DATA_BYTES));
    if (w_remaining < w_to_4k) begin
      w_limit = w_remaining;
    end else begin
      w_limit = w_to_4k;
    end
    if (32'(i_data_available) > 32'(MAX_BURST)) begin
      w_avail_cap = LEN_W'(MAX_BURST);
    end else begin
      w_avail_cap = LEN_W'(i_data_available);
    end
  end

  // Planner FSM with all plan/status outputs registered; arm overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_low        <= '0;
      r_high       <= '0;
      r_offset     <= '0;
      r_cand       <= '0;
      r_plan_valid <= 1'b0;
      r_plan_addr  <= '0;
      r_plan_beats <= '0;
      r_plan_awlen <= 8'd0;
      r_full       <= 1'b0;
      r_wrap_cnt   <= 16'd0;
      r_busy       <= 1'b0;
    end else if (i_arm) begin
      r_state      <= ST_SCAN;
      r_low        <= i_addr_low;
      r_high       <= i_addr_high;
      r_offset     <= '0;
      r_wrap_cnt   <= 16'd0;
      r_full       <= 1'b0;
      r_busy       <= 1'b1;
      r_plan_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_IDLE;
        end
        ST_SCAN: begin
          if (w_exhausted) begin
`ifdef AH_PL2DDR_PLAN_WRAP_EN
            r_offset <= '0;
            if (r_wrap_cnt != 16'hFFFF) begin
              r_wrap_cnt <= r_wrap_cnt + 16'd1;
            end else begin
              r_wrap_cnt <= r_wrap_cnt;
            end
`else
            r_state <= ST_FULL;
            r_full  <= 1'b1;
            r_busy  <= 1'b0;
`endif
          end else if (i_data_available != '0) begin
            // Fill level is captured here only; later changes cannot disturb the plan.
            r_cand      <= pow2_floor(w_avail_cap);
            r_plan_addr <= w_scan_addr;
            r_state     <= ST_TRIM;
          end else begin
            r_state <= ST_SCAN;
          end
        end
        ST_TRIM: begin
          if (w_cand_bytes <= w_limit) begin
            r_plan_valid <= 1'b1;
            r_plan_beats <= r_cand;
            r_plan_awlen <= 8'(r_cand - LEN_W'(1));
            r_state      <= ST_OFFER;
          end else begin
            r_cand <= r_cand >> 1;
          end
        end
        ST_OFFER: begin
          if (plan_if.plan_ready) begin
            r_offset     <= r_offset + w_beat_bytes;
            r_plan_valid <= 1'b0;
            r_state      <= ST_BUSY;
          end else begin
            r_state <= ST_OFFER;
          end
        end
        ST_BUSY: begin
          if (i_burst_done) begin
            r_state <= ST_SCAN;
          end else begin
            r_state <= ST_BUSY;
          end
        end
        ST_FULL: begin
          r_state <= ST_FULL;
        end
        default: begin
          r_state      <= ST_IDLE;
          r_plan_valid <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign plan_if.plan_valid = r_plan_valid;
  assign plan_if.plan_addr  = r_plan_addr;
  assign plan_if.plan_beats = r_plan_beats;
  assign plan_if.plan_awlen = r_plan_awlen;
  assign o_offset           = r_offset;
  assign o_full             = r_full;
  assign o_wrap_cnt         = r_wrap_cnt;
  assign o_busy             = r_busy;

endmodule
